// File: rtl/param_value_checker.sv
// -----------------------------------------------------------------------------
// param_value_checker
//
// Samples a WIDTH-bit value bus for DEPTH consecutive cycles after an optional
// SETTLE delay. It reports whether every sample equalled EXPECT[WIDTH-1:0], how
// many samples mismatched (saturating), and the first mismatching value.
//
// Ports:
//   clk            - rising-edge clock
//   rst_n          - asynchronous active-low reset
//   start          - request a check (only honoured in IDLE)
//   value          - bus under test
//   busy           - high while a check is in SETTLE or SAMPLE
//   done           - one-cycle pulse while the result is reported
//   result_valid   - sticky from done until the next accepted start
//   pass           - mismatch_count == 0 (meaningful while result_valid)
//   mismatch_count - saturating count of mismatching samples
//   first_bad      - value of the first mismatching sample, 0 if none
// -----------------------------------------------------------------------------
module param_value_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 2,
    parameter logic [63:0] EXPECT = 64'd0,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [WIDTH-1:0] first_bad
);

    // Only the low WIDTH bits of EXPECT matter; wider overrides are truncated.
    localparam logic [WIDTH-1:0] EXP_C       = WIDTH'(EXPECT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE) - 32'd1;
    localparam logic [31:0]      SAMPLE_LAST = 32'(DEPTH) - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        step_r;
    logic               settle_last_s;
    logic               sample_last_s;
    logic               mism_s;
    logic [CNT_W-1:0]   cnt_next_s;

    logic               busy_r;
    logic               done_r;
    logic               rv_r;
    logic               pass_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   fb_r;

    // Compare and step-counter decode; an X/Z compare falls to the mismatch branch.
    always_comb begin
        mism_s        = 1'b1;
        settle_last_s = 1'b0;
        sample_last_s = 1'b0;
        cnt_next_s    = cnt_r;
        if (value == EXP_C) begin
            mism_s = 1'b0;
        end else begin
            mism_s = 1'b1;
        end
        if (step_r == SETTLE_LAST) begin
            settle_last_s = 1'b1;
        end else begin
            settle_last_s = 1'b0;
        end
        if (step_r == SAMPLE_LAST) begin
            sample_last_s = 1'b1;
        end else begin
            sample_last_s = 1'b0;
        end
        // Saturating increment: the count holds at its maximum instead of wrapping.
        if (mism_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Next-state logic for the check sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (SETTLE > 0) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_SAMPLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last_s) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (sample_last_s) begin
                    state_s = ST_REPORT;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            ST_REPORT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Step counter, result registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r <= 32'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            rv_r   <= 1'b0;
            pass_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            fb_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        step_r <= 32'd0;
                        busy_r <= 1'b1;
                        rv_r   <= 1'b0;
                        pass_r <= 1'b0;
                        cnt_r  <= {CNT_W{1'b0}};
                        fb_r   <= {WIDTH{1'b0}};
                    end
                end
                ST_SETTLE: begin
                    // Reused as the sample index once the settle period ends.
                    if (settle_last_s) begin
                        step_r <= 32'd0;
                    end else begin
                        step_r <= step_r + 32'd1;
                    end
                end
                ST_SAMPLE: begin
                    step_r <= step_r + 32'd1;
                    cnt_r  <= cnt_next_s;
                    // The count never wraps, so zero means no mismatch seen yet.
                    if (mism_s && (cnt_r == {CNT_W{1'b0}})) begin
                        fb_r <= value;
                    end
                    // Result is registered with the last sample so it is visible during REPORT.
                    if (sample_last_s) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        rv_r   <= 1'b1;
                        pass_r <= (cnt_next_s == {CNT_W{1'b0}});
                    end
                end
                ST_REPORT: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign result_valid   = rv_r;
    assign pass           = pass_r;
    assign mismatch_count = cnt_r;
    assign first_bad      = fb_r;

endmodule

// File: tb/tb_param_value_checker.sv
// Bench for param_value_checker: two instances (SETTLE=1/DEPTH=4/EXPECT=AB and
// SETTLE=0/DEPTH=6/EXPECT=1CD truncated/CNT_W=2) checked against a timeline
// model that derives sample edges and results from the accept edge.
module tb_param_value_checker;

    typedef struct {
        int         inst;
        int         cnt;
        logic [7:0] fb;
        logic       ok;
    } res_t;

    localparam int         S_A   [2] = '{1, 0};
    localparam int         D_A   [2] = '{4, 6};
    localparam logic [7:0] EXP_A [2] = '{8'hAB, 8'hCD};
    localparam int         MAX_A [2] = '{255, 3};

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] start  = 2'b00;
    logic [7:0] value0 = 8'h00;
    logic [7:0] value1 = 8'h00;

    logic       busy0, done0, rv0, pass0;
    logic       busy1, done1, rv1, pass1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] fb0, fb1;

    int checks = 0;
    int errors = 0;

    res_t       sbq [$];
    int         ecnt = 0;
    int         acc   [2] = '{-1, -1};
    int         nfree [2] = '{0, 0};
    int         nmis  [2] = '{0, 0};
    logic [7:0] fbm   [2] = '{8'h00, 8'h00};
    logic       eb    [2] = '{1'b0, 1'b0};
    logic       ed    [2] = '{1'b0, 1'b0};
    logic       erv   [2] = '{1'b0, 1'b0};
    logic       ep    [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    param_value_checker #(
        .WIDTH(8), .DEPTH(4), .EXPECT(64'hAB), .SETTLE(1), .CNT_W(8)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .value(value0),
        .busy(busy0), .done(done0), .result_valid(rv0), .pass(pass0),
        .mismatch_count(cnt0), .first_bad(fb0)
    );

    param_value_checker #(
        .WIDTH(8), .DEPTH(6), .EXPECT(64'h1CD), .SETTLE(0), .CNT_W(2)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .value(value1),
        .busy(busy1), .done(done1), .result_valid(rv1), .pass(pass1),
        .mismatch_count(cnt1), .first_bad(fb1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accept at edge A puts samples on edges A+S+1..A+S+D.
    task automatic model_step();
        logic [7:0] v;
        res_t       r;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                acc[i] = -1; nfree[i] = 0; nmis[i] = 0; fbm[i] = 8'h00;
                eb[i] = 1'b0; ed[i] = 1'b0; erv[i] = 1'b0; ep[i] = 1'b0;
            end
            sbq.delete();
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                v = (i == 0) ? value0 : value1;
                if (ecnt >= nfree[i] && start[i]) begin
                    acc[i]   = ecnt;
                    nfree[i] = ecnt + S_A[i] + D_A[i] + 2;
                    nmis[i]  = 0;
                    fbm[i]   = 8'h00;
                    erv[i]   = 1'b0;
                    ep[i]    = 1'b0;
                end
                if (acc[i] >= 0 && ecnt > acc[i] + S_A[i] && ecnt <= acc[i] + S_A[i] + D_A[i]) begin
                    if (v !== EXP_A[i]) begin
                        if (nmis[i] == 0) fbm[i] = v;
                        nmis[i]++;
                    end
                    if (ecnt == acc[i] + S_A[i] + D_A[i]) begin
                        r.inst = i;
                        r.cnt  = (nmis[i] > MAX_A[i]) ? MAX_A[i] : nmis[i];
                        r.fb   = fbm[i];
                        r.ok   = (nmis[i] == 0);
                        sbq.push_back(r);
                        erv[i] = 1'b1;
                        ep[i]  = (nmis[i] == 0);
                    end
                end
                eb[i] = (acc[i] >= 0) && (ecnt >= acc[i]) && (ecnt < acc[i] + S_A[i] + D_A[i]);
                ed[i] = (acc[i] >= 0) && (ecnt == acc[i] + S_A[i] + D_A[i]);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    task automatic mon(input int i, input logic b, input logic d, input logic rv,
                       input logic p, input logic [7:0] c, input logic [7:0] f);
        int k;
        chk($sformatf("busy%0d", i), b, eb[i]);
        chk($sformatf("done%0d", i), d, ed[i]);
        chk($sformatf("result_valid%0d", i), rv, erv[i]);
        chk($sformatf("pass%0d", i), p, ep[i]);
        if (d === 1'b1) begin
            k = -1;
            foreach (sbq[j]) begin
                if (k < 0 && sbq[j].inst == i) k = j;
            end
            chk($sformatf("sb_entry%0d", i), (k >= 0), 1'b1);
            if (k >= 0) begin
                chk($sformatf("mismatch_count%0d", i), c, sbq[k].cnt);
                chk($sformatf("first_bad%0d", i), f, sbq[k].fb);
                chk($sformatf("pass_at_done%0d", i), p, sbq[k].ok);
                sbq.delete(k);
            end
        end
    endtask

    // Monitor: samples outputs on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            mon(0, busy0, done0, rv0, pass0, cnt0, fb0);
            mon(1, busy1, done1, rv1, pass1, {6'd0, cnt1}, fb1);
        end
    end

    task automatic cyc(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start  = s;
        value0 = a;
        value1 = b;
    endtask

    task automatic idle(input int n, input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < n; k++) cyc(2'b00, a, b);
    endtask

    initial begin
        logic [7:0] r0, r1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All samples match on instance 0.
        cyc(2'b01, 8'hAB, 8'hCD);
        idle(9, 8'hAB, 8'hCD);

        // Mismatches on the 2nd and 4th samples.
        cyc(2'b01, 8'hAB, 8'hCD);
        cyc(2'b00, 8'hAB, 8'hCD);
        cyc(2'b00, 8'hAB, 8'hCD);
        cyc(2'b00, 8'hCD, 8'hCD);
        cyc(2'b00, 8'hAB, 8'hCD);
        cyc(2'b00, 8'hEE, 8'hCD);
        idle(4, 8'hAB, 8'hCD);

        // Truncated EXPECT with SETTLE=0, then saturating count.
        cyc(2'b10, 8'hAB, 8'hCD);
        idle(9, 8'hAB, 8'hCD);
        cyc(2'b10, 8'hAB, 8'h00);
        idle(10, 8'hAB, 8'h00);

        // Reset asserted during instance 0's second sample cycle.
        cyc(2'b11, 8'hAB, 8'hCD);
        cyc(2'b00, 8'hAB, 8'hCD);
        cyc(2'b00, 8'hAB, 8'hCD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_rv0", rv0, 1'b0);
        chk("rst_cnt0", cnt0, 8'd0);
        chk("rst_fb0", fb0, 8'd0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_cnt1", cnt1, 2'd0);
        chk("rst_fb1", fb1, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b01, 8'hAB, 8'hCD);
        idle(8, 8'hAB, 8'hCD);

        // start toggled during a check, then held high.
        cyc(2'b11, 8'hAB, 8'hCD);
        for (int k = 1; k <= 6; k++) cyc((k % 2 == 1) ? 2'b11 : 2'b00, 8'hAB, 8'h12);
        for (int k = 0; k < 24; k++) cyc(2'b11, (k % 5 == 0) ? 8'h55 : 8'hAB, (k % 3 == 0) ? 8'hCD : 8'h77);

        // Randomized phase.
        for (int k = 0; k < 800; k++) begin
            r0 = ($urandom_range(0, 1) == 0) ? 8'hAB : 8'($urandom);
            r1 = ($urandom_range(0, 1) == 0) ? 8'hCD : 8'($urandom);
            cyc({($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)}, r0, r1);
        end
        idle(14, 8'hAB, 8'hCD);

        chk("sb_drain", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_value_checker.md
Name: param_value_checker

Overview:
- Sequential checker that samples a parameter-configured value bus and reports whether it holds a parameter-configured expected value.
- Acts as the consuming end of parameter-overridden constant sources such as defparam targets: the source drives a WIDTH-bit value, and this block reads it for DEPTH consecutive cycles.
- Reports pass/fail, mismatch count and the first bad sample.
- Instanced in self-checking benches and regression harnesses, typically with its own parameters overridden by defparam alongside the source it checks.

Parameters:
- WIDTH, 4, width of the checked value bus.
- DEPTH, 2, number of consecutive samples compared per check; legal range is 1 or more.
- EXPECT, 0, expected value; only bits [WIDTH-1:0] are used (truncated, never sign-extended).
- SETTLE, 1, idle cycles between start acceptance and the first sample; 0 is legal.
- CNT_W, 8, width of mismatch_count.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a check; sampled only in IDLE.
- value  in  WIDTH  bus under test.
- busy  out  1  high while a check is in progress (SETTLE or SAMPLE state).
- done  out  1  one-cycle pulse when a result is produced.
- result_valid  out  1  sticky; high from done until the next accepted start.
- pass  out  1  meaningful only while result_valid=1: high when mismatch_count==0.
- mismatch_count  out  CNT_W  number of samples with value != EXPECT; saturates at 2^CNT_W-1.
- first_bad  out  WIDTH  value captured at the first mismatching sample; 0 if there was none.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all counters 0, and every output 0.
- On rst_n deassertion, the block leaves reset and waits in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SETTLE, SAMPLE, REPORT.
- IDLE:
  - start=1 at an edge accepts a check. On that edge: mismatch_count, first_bad, result_valid and pass are cleared, and busy is set.
  - Next state is SETTLE if SETTLE>0, otherwise SAMPLE.
- SETTLE:
  - A counter runs for exactly SETTLE edges, then the state moves to SAMPLE.
  - value is ignored in this state.
- SAMPLE:
  - Each edge compares value against EXPECT[WIDTH-1:0], for exactly DEPTH edges.
  - On a mismatch, mismatch_count increments (holding at its maximum, no wrap).
  - first_bad is loaded only on the first mismatch of the check.
  - After the DEPTH-th sample edge, the state moves to REPORT and busy drops.
- REPORT:
  - Lasts one cycle: done=1.
  - result_valid is set, and pass is set if mismatch_count==0.
  - Next state is IDLE, and done returns to 0.
- Latency: with start accepted at edge 0, samples occur at edges S+1..S+D (S=SETTLE, D=DEPTH), and done is high in the cycle after edge S+D.
- Back-to-back checks: start may be high during REPORT, but it is ignored there. It is accepted at the first IDLE edge, so the minimum spacing between accepted starts is S+D+2 edges.
- start while busy or in REPORT is ignored; there is no queuing and no error flag.
- start held high continuously produces repeated checks, each accepted on entry to IDLE.
- Reset mid-check aborts immediately. No done pulse is emitted and all results read 0.
- The block contains no X-propagation logic: value bits that are X or Z compare as mismatches under 4-state simulation semantics (!= yields X, which is treated as mismatch).

Test Plan:
- WIDTH=8, DEPTH=4, EXPECT=8'hAB, SETTLE=1; value held at 8'hAB; start pulsed at edge 0 -> busy high edges 0..5, done pulse in the cycle after edge 5, pass=1, mismatch_count=0, first_bad=0.
- Same configuration; value=8'hAB except 8'hCD on the 2nd sample and 8'hEE on the 4th -> mismatch_count=2, first_bad=8'hCD, pass=0, result_valid=1.
- defparam overrides WIDTH=8, DEPTH=2, EXPECT=8'h1CD (truncated to 8'hCD), SETTLE=0; value=8'hCD -> first sample at edge 1, done after edge 2, pass=1.
- CNT_W=2, DEPTH=6, value never matching -> mismatch_count saturates at 3, pass=0.
- Reset mid-check: rst_n low during the 2nd SAMPLE cycle -> all outputs 0 immediately and no done pulse. A new start after release completes a normal check.
- start toggled during SETTLE, SAMPLE and REPORT -> ignored. start held high afterwards -> next check accepted at the first IDLE edge and result_valid cleared on that edge.
